// File: rtl/serial_code_converter_if.sv
// Serial bit stream plus framing/status strobes between a source/sink and serial_code_converter.
interface serial_code_converter_if #(
  parameter int DIGITS = 4
);
  localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic            En;
  logic            X;
  logic            Dir;
  logic            Z;
  logic            Z_valid;
  logic [IDXW-1:0] Digit_idx;
  logic            Digit_done;
  logic            Err;
  logic            Word_done;
  logic            Word_err;

  modport master (
    output En, X, Dir,
    input  Z, Z_valid, Digit_idx, Digit_done, Err, Word_done, Word_err
  );

  modport slave (
    input  En, X, Dir,
    output Z, Z_valid, Digit_idx, Digit_done, Err, Word_done, Word_err
  );
endinterface

// File: rtl/serial_code_converter.sv
// Serial LSB-first Excess-3 <-> BCD converter (Mealy), DIGITS digits per word,
// with bit-enable stalling, digit/word strobes and invalid-code flags.
module serial_code_converter #(
  parameter int DIGITS = 4
) (
  input  logic                     Clk,
  input  logic                     Rst,
  serial_code_converter_if.slave   bus
);
  localparam int              IDXW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [3:0]      K        = 4'b0011;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DIGITS - 1);

  typedef enum logic [1:0] {BIT0, BIT1, BIT2, BIT3} bit_e;

  bit_e            bit_q, bit_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            c_q, c_d;
  logic [2:0]      din_q, din_d;
  logic            dir_q, dir_d;
  logic            werr_q, werr_d;
  logic            dd_q, dd_d;
  logic            err_q, err_d;
  logic            wd_q, wd_d;
  logic            we_q, we_d;

  logic       word_start, d, k, cin, zbit, cout, invalid, last, digit_end;
  logic [3:0] v;

  // Bit-serial add/subtract of K; only the low 3 input bits need storing since bit 3 is live on X.
  always_comb begin
    word_start = (bit_q == BIT0) && (idx_q == '0);
    d          = word_start ? bus.Dir : dir_q;
    k          = K[bit_q];
    cin        = (bit_q == BIT0) ? 1'b0 : c_q;
    zbit       = bus.X ^ k ^ cin;
    cout       = d ? ((bus.X & k) | (bus.X & cin) | (k & cin))
                   : ((~bus.X & (k | cin)) | (k & cin));
    v          = {bus.X, din_q};
    invalid    = d ? (v > 4'd9) : ((v < 4'd3) || (v > 4'd12));
    last       = (idx_q == LAST_IDX);
    digit_end  = bus.En && (bit_q == BIT3);
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      bit_q  <= BIT0;
      idx_q  <= '0;
      c_q    <= 1'b0;
      din_q  <= '0;
      dir_q  <= 1'b0;
      werr_q <= 1'b0;
      dd_q   <= 1'b0;
      err_q  <= 1'b0;
      wd_q   <= 1'b0;
      we_q   <= 1'b0;
    end else begin
      bit_q  <= bit_d;
      idx_q  <= idx_d;
      c_q    <= c_d;
      din_q  <= din_d;
      dir_q  <= dir_d;
      werr_q <= werr_d;
      dd_q   <= dd_d;
      err_q  <= err_d;
      wd_q   <= wd_d;
      we_q   <= we_d;
    end
  end

  always_comb begin
    bit_d  = bit_q;
    idx_d  = idx_q;
    c_d    = c_q;
    din_d  = din_q;
    dir_d  = dir_q;
    werr_d = werr_q;
    dd_d   = digit_end;
    err_d  = digit_end && invalid;
    wd_d   = digit_end && last;
    we_d   = digit_end && last && (werr_q || invalid);
    if (bus.En) begin
      c_d = cout;
      if (word_start) dir_d = bus.Dir;
      case (bit_q)
        BIT0:    begin din_d[0] = bus.X; bit_d = BIT1; end
        BIT1:    begin din_d[1] = bus.X; bit_d = BIT2; end
        BIT2:    begin din_d[2] = bus.X; bit_d = BIT3; end
        default: begin
          bit_d  = BIT0;
          idx_d  = last ? '0 : idx_q + IDXW'(1);
          werr_d = last ? 1'b0 : (werr_q | invalid);
        end
      endcase
    end
  end

  always_comb begin
    bus.Z          = bus.En & zbit;
    bus.Z_valid    = bus.En;
    bus.Digit_idx  = idx_q;
    bus.Digit_done = dd_q;
    bus.Err        = err_q;
    bus.Word_done  = wd_q;
    bus.Word_err   = we_q;
  end
endmodule

// File: tb/tb_serial_code_converter.sv
// Scoreboard bench: one DIGITS=1 and one DIGITS=2 converter checked against an arithmetic model.
module tb_serial_code_converter;
  logic Clk = 1'b0;
  logic Rst;
  always #5 Clk = ~Clk;

  serial_code_converter_if #(.DIGITS(1)) b1 ();
  serial_code_converter_if #(.DIGITS(2)) b2 ();

  serial_code_converter #(.DIGITS(1)) u1 (.Clk(Clk), .Rst(Rst), .bus(b1));
  serial_code_converter #(.DIGITS(2)) u2 (.Clk(Clk), .Rst(Rst), .bus(b2));

  typedef struct { logic [1:0] z; logic [1:0] zv; } ez_t;
  typedef struct { logic [1:0] dd; logic [1:0] er; logic [1:0] wd; logic [1:0] we; int idx0; int idx1; } er_t;

  ez_t qz[$];
  er_t qr[$];

  int n_checks = 0;
  int n_errors = 0;

  int         m_bp[2];
  int         m_idx[2];
  int         ndig[2];
  logic [3:0] m_din[2];
  logic       m_dir[2];
  logic       m_werr[2];
  logic [3:0] zcap;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_bp[i] = 0; m_idx[i] = 0; m_din[i] = '0; m_dir[i] = 1'b0; m_werr[i] = 1'b0;
    end
  endtask

  // Z bit n of (v +/- 3) depends only on input bits 0..n, so a partial digit suffices.
  task automatic model_step(input int i, input logic en, input logic x, input logic dir,
                            output logic z, output logic zv, output logic dd,
                            output logic er, output logic wd, output logic we);
    logic       d, inval, last;
    logic [3:0] vp, r;
    z = 1'b0; zv = en; dd = 1'b0; er = 1'b0; wd = 1'b0; we = 1'b0;
    d  = (m_bp[i] == 0 && m_idx[i] == 0) ? dir : m_dir[i];
    vp = m_din[i] | (4'(x) << m_bp[i]);
    r  = d ? vp + 4'd3 : vp - 4'd3;
    if (en) begin
      z = r[m_bp[i]];
      if (m_bp[i] == 0 && m_idx[i] == 0) m_dir[i] = dir;
      m_din[i] = vp;
      if (m_bp[i] == 3) begin
        inval     = d ? (vp > 4'd9) : (vp < 4'd3 || vp > 4'd12);
        last      = (m_idx[i] == ndig[i] - 1);
        dd        = 1'b1;
        er        = inval;
        wd        = last;
        we        = last && (m_werr[i] || inval);
        m_werr[i] = last ? 1'b0 : (m_werr[i] | inval);
        m_idx[i]  = last ? 0 : m_idx[i] + 1;
        m_din[i]  = '0;
        m_bp[i]   = 0;
      end else begin
        m_bp[i]++;
      end
    end
  endtask

  task automatic cycle(input int sel, input logic en, input logic x, input logic dir);
    ez_t  ez;
    er_t  e;
    logic z, zv, dd, er, wd, we, oz;
    b1.En = (sel == 0) && en; b1.X = x; b1.Dir = dir;
    b2.En = (sel == 1) && en; b2.X = x; b2.Dir = dir;
    for (int i = 0; i < 2; i++) begin
      model_step(i, (i == sel) && en, x, dir, z, zv, dd, er, wd, we);
      ez.z[i] = z; ez.zv[i] = zv;
      e.dd[i] = dd; e.er[i] = er; e.wd[i] = wd; e.we[i] = we;
    end
    e.idx0 = m_idx[0];
    e.idx1 = m_idx[1];
    qz.push_back(ez);
    qr.push_back(e);

    @(negedge Clk);
    ez = qz.pop_front();
    check("Z_d1", b1.Z, ez.z[0]);
    check("Zvalid_d1", b1.Z_valid, ez.zv[0]);
    check("Z_d2", b2.Z, ez.z[1]);
    check("Zvalid_d2", b2.Z_valid, ez.zv[1]);
    oz = (sel == 0) ? b1.Z : b2.Z;
    if (en) zcap = {oz, zcap[3:1]};

    @(posedge Clk); #1;
    e = qr.pop_front();
    check("idx_d1", b1.Digit_idx, e.idx0);
    check("ddone_d1", b1.Digit_done, e.dd[0]);
    check("err_d1", b1.Err, e.er[0]);
    check("wdone_d1", b1.Word_done, e.wd[0]);
    check("werr_d1", b1.Word_err, e.we[0]);
    check("idx_d2", b2.Digit_idx, e.idx1);
    check("ddone_d2", b2.Digit_done, e.dd[1]);
    check("err_d2", b2.Err, e.er[1]);
    check("wdone_d2", b2.Word_done, e.wd[1]);
    check("werr_d2", b2.Word_err, e.we[1]);
  endtask

  task automatic run_digit(input int sel, input logic dir, input logic [3:0] v,
                           input logic [3:0] zexp, input string tag);
    for (int b = 0; b < 4; b++) cycle(sel, 1'b1, v[b], dir);
    check(tag, zcap, zexp);
  endtask

  task automatic hard_reset();
    b1.En = 1'b0; b2.En = 1'b0;
    Rst = 1'b1;
    #2;
    model_reset();
    check("rst_idx_d1", b1.Digit_idx, 0);
    check("rst_strobes_d1", {b1.Digit_done, b1.Err, b1.Word_done, b1.Word_err}, 0);
    check("rst_idx_d2", b2.Digit_idx, 0);
    check("rst_strobes_d2", {b2.Digit_done, b2.Err, b2.Word_done, b2.Word_err}, 0);
    check("rst_z", {b1.Z, b1.Z_valid, b2.Z, b2.Z_valid}, 0);
    @(negedge Clk);
    Rst = 1'b0;
    @(posedge Clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    Rst = 1'b1;
    b1.En = 1'b0; b1.X = 1'b0; b1.Dir = 1'b0;
    b2.En = 1'b0; b2.X = 1'b0; b2.Dir = 1'b0;
    zcap = '0;
    ndig[0] = 1; ndig[1] = 2;
    model_reset();
    @(posedge Clk); #1;
    hard_reset();

    run_digit(0, 1'b0, 4'b0101, 4'b0010, "e3_0101");
    run_digit(0, 1'b0, 4'b1100, 4'b1001, "e3_1100");
    run_digit(0, 1'b0, 4'b0001, 4'b1110, "e3_0001_invalid");
    run_digit(0, 1'b1, 4'b0111, 4'b1010, "bcd_0111");
    run_digit(0, 1'b1, 4'b1010, 4'b1101, "bcd_1010_invalid");
    cycle(0, 1'b0, 1'b0, 1'b0);

    cycle(1, 1'b1, 1'b0, 1'b0);
    cycle(1, 1'b1, 1'b1, 1'b0);
    repeat (3) cycle(1, 1'b0, 1'b1, 1'b1);
    cycle(1, 1'b1, 1'b1, 1'b0);
    cycle(1, 1'b1, 1'b0, 1'b0);
    check("stall_digit0", zcap, 4'b0011);
    run_digit(1, 1'b0, 4'b1000, 4'b0101, "stall_digit1");

    cycle(1, 1'b1, 1'b0, 1'b1);
    cycle(1, 1'b1, 1'b0, 1'b0);
    cycle(1, 1'b1, 1'b1, 1'b0);
    cycle(1, 1'b1, 1'b0, 1'b0);
    check("dirlatch_digit0", zcap, 4'b0111);
    run_digit(1, 1'b0, 4'b0010, 4'b0101, "dirlatch_digit1");
    run_digit(1, 1'b0, 4'b0101, 4'b0010, "redir_digit0");
    run_digit(1, 1'b1, 4'b1001, 4'b0110, "redir_digit1");

    run_digit(1, 1'b0, 4'b0111, 4'b0100, "prereset_digit0");
    cycle(1, 1'b1, 1'b1, 1'b0);
    cycle(1, 1'b1, 1'b0, 1'b0);
    hard_reset();
    run_digit(1, 1'b0, 4'b0101, 4'b0010, "postreset_digit0");
    run_digit(1, 1'b0, 4'b1111, 4'b1100, "postreset_digit1_invalid");

    repeat (80) begin
      cycle(int'($urandom_range(0, 1)), $urandom_range(0, 3) != 0,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
